alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial sequencer that sits directly upstream of the 1-bit reversible ALU and also consumes its outputs.
- Accepts a WIDTH-bit operation over a valid/ready handshake and drives the ALU's single-bit A/B/C inputs LSB-first, one bit per clock.
- Samples the ALU's combinational Sum/Carry, Diff/Bout and logic outputs each cycle, and feeds carry or borrow back through C.
- Assembles a WIDTH-bit result, presented with a flag on a valid/ready output.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..16.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  operation request.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- in_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101..111 reserved.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- alu_a  output  1  current A bit to ALU.
- alu_b  output  1  current B bit to ALU.
- alu_c  output  1  carry-in/borrow-in to ALU.
- alu_sum, alu_carry  input  1 each  full-adder outputs.
- alu_diff, alu_bout  input  1 each  subtractor outputs.
- alu_and, alu_or, alu_xor  input  1 each  logic outputs.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  assembled result.
- out_flag  output  1  ADD: carry-out; SUB: borrow-out (1 iff a<b unsigned); logic ops: 0.
- out_illegal  output  1  result came from a reserved opcode.

Behaviour:
- Reset (async assert, sync release), all values immediate:
  - state=IDLE, in_ready=1, out_valid=0, out_result=0, out_flag=0, out_illegal=0.
  - alu_a=alu_b=alu_c=0.
  - Internal operand shift registers, bit counter and carry register cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; alu_a/b/c=0.
  - On an edge with in_valid=1, latch in_a, in_b, in_op; clear carry register and counter.
  - Next state: RUN for legal ops; DONE directly for reserved ops, with out_result=0, out_flag=0, out_illegal=1.
- RUN:
  - in_ready=0. Combinational drive: alu_a=a_sh[0], alu_b=b_sh[0].
  - alu_c = carry register for ADD/SUB, 0 for logic ops.
  - Each edge:
    - Selected ALU bit is shifted into result MSB (right shift), so after WIDTH edges bit i sits at position i. Selection: ADD→alu_sum, SUB→alu_diff, AND/OR/XOR→alu_and/alu_or/alu_xor.
    - Carry register <= alu_carry (ADD) or alu_bout (SUB), else 0.
    - Operand registers shift right; counter increments.
  - On the edge where counter==WIDTH-1: go to DONE; out_flag <= final carry/borrow; out_illegal <= 0.
- DONE:
  - out_valid=1; out_result, out_flag and out_illegal held stable until accepted; alu_a/b/c=0.
  - On an edge with out_ready=1, go to IDLE and out_valid <= 0.
  - out_result, out_flag and out_illegal keep their last values after the handshake.
- Latency: accept at edge T → out_valid high after edge T+WIDTH (reserved op: after T+1). Throughput is one op per WIDTH+2 cycles with out_ready held high.
- Boundaries:
  - in_valid while in RUN or DONE is ignored; in_ready=0 and the operands are not latched.
  - out_ready while out_valid=0 has no effect.
  - ADD overflow wraps modulo 2^WIDTH; out_flag=1.
  - SUB underflow wraps modulo 2^WIDTH (two's complement); out_flag=1.
  - rst_n low mid-RUN or mid-DONE aborts immediately to the reset state; the partial result is discarded and no out_valid is produced.
  - Operands are sampled only at acceptance; later in_a/in_b changes have no effect.

Test Plan:
- WIDTH=4, ADD a=7 b=5 → out_valid 4 cycles after accept, result=12, flag=0, illegal=0; alu_c sequence over the 4 RUN cycles = 0,1,1,1.
- ADD a=9 b=9 → result=2, flag=1. SUB a=3 b=5 → result=14, flag=1. SUB a=12 b=4 → result=8, flag=0.
- AND a=0xC b=0xA → 0x8; OR → 0xE; XOR → 0x6; flag=0 and alu_c=0 throughout RUN.
- Opcode 110 → out_valid after 1 cycle, result=0, illegal=1. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0, a new in_valid is ignored; raise out_ready → IDLE.
- Pull rst_n low during the 2nd RUN cycle of ADD 15+1 → all outputs return to reset values asynchronously. After release, ADD 1+1 → result=2 with no stale carry.
- Back-to-back: in_valid and out_ready held high, ops ADD 3+4 then SUB 2-1 → results 7 then 1; second accept occurs exactly WIDTH+2 cycles after the first.

Source files
------------

// File: rtl/alu_serial_seq_if.sv
// alu_serial_seq_if: bundles the request, result and 1-bit ALU signals of the
// bit-serial sequencer.
//   in_valid/in_ready/in_op/in_a/in_b     : operation request handshake
//   out_valid/out_ready/out_result/
//   out_flag/out_illegal                   : result handshake
//   alu_a/alu_b/alu_c                      : bit drive to the 1-bit ALU
//   alu_sum/alu_carry/alu_diff/alu_bout/
//   alu_and/alu_or/alu_xor                 : combinational ALU outputs
// modport slave  : the sequencer
// modport master : the environment (requester, consumer and ALU)
interface alu_serial_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_flag;
    logic             out_illegal;

    logic             alu_a;
    logic             alu_b;
    logic             alu_c;
    logic             alu_sum;
    logic             alu_carry;
    logic             alu_diff;
    logic             alu_bout;
    logic             alu_and;
    logic             alu_or;
    logic             alu_xor;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        input  alu_sum, alu_carry, alu_diff, alu_bout, alu_and, alu_or, alu_xor,
        output in_ready, out_valid, out_result, out_flag, out_illegal,
        output alu_a, alu_b, alu_c
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        output alu_sum, alu_carry, alu_diff, alu_bout, alu_and, alu_or, alu_xor,
        input  in_ready, out_valid, out_result, out_flag, out_illegal,
        input  alu_a, alu_b, alu_c
    );
endinterface

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer around a 1-bit ALU. Accepts a WIDTH-bit
// op, drives operand bits LSB-first for WIDTH cycles with carry/borrow fed back
// through alu_c, assembles the result and presents it with a flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_serial_seq_if.slave (request, result and ALU bit signals)
module alu_serial_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_serial_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } op_e;

    state_e           state, state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] a_sh, b_sh, res_q;
    logic [CW-1:0]    cnt;
    logic             carry_q, flag_q, illegal_q;

    logic             op_legal, last_bit, arith, bit_sel, carry_nxt;

    assign op_legal = (bus.in_op <= 3'b100);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign arith    = (op_q == OP_ADD) || (op_q == OP_SUB);

    // ALU output selection and carry/borrow feedback for the current bit
    always_comb begin
        bit_sel   = 1'b0;
        carry_nxt = 1'b0;
        unique case (op_q)
            OP_ADD: begin bit_sel = bus.alu_sum;  carry_nxt = bus.alu_carry; end
            OP_SUB: begin bit_sel = bus.alu_diff; carry_nxt = bus.alu_bout;  end
            OP_AND: bit_sel = bus.alu_and;
            OP_OR:  bit_sel = bus.alu_or;
            OP_XOR: bit_sel = bus.alu_xor;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.alu_a      = 1'b0;
        bus.alu_b      = 1'b0;
        bus.alu_c      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = op_legal ? RUN : DONE;
            end
            RUN: begin
                bus.alu_a = a_sh[0];
                bus.alu_b = b_sh[0];
                bus.alu_c = arith ? carry_q : 1'b0;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            a_sh      <= '0;
            b_sh      <= '0;
            res_q     <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            flag_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh    <= bus.in_a;
                        b_sh    <= bus.in_b;
                        carry_q <= 1'b0;
                        cnt     <= '0;
                        if (op_legal) begin
                            op_q <= op_e'(bus.in_op);
                        end else begin
                            res_q     <= '0;
                            flag_q    <= 1'b0;
                            illegal_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // right shift: after WIDTH edges bit i lands at position i
                    res_q   <= {bit_sel, res_q[WIDTH-1:1]};
                    carry_q <= carry_nxt;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        flag_q    <= carry_nxt;
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_result  = res_q;
    assign bus.out_flag    = flag_q;
    assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
module tb_alu_serial_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    alu_serial_seq_if #(.WIDTH(W)) bus ();

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference 1-bit reversible ALU
    assign bus.alu_sum   = bus.alu_a ^ bus.alu_b ^ bus.alu_c;
    assign bus.alu_carry = (bus.alu_a & bus.alu_b) | (bus.alu_c & (bus.alu_a ^ bus.alu_b));
    assign bus.alu_diff  = bus.alu_a ^ bus.alu_b ^ bus.alu_c;
    assign bus.alu_bout  = (~bus.alu_a & bus.alu_b) | (~(bus.alu_a ^ bus.alu_b) & bus.alu_c);
    assign bus.alu_and   = bus.alu_a & bus.alu_b;
    assign bus.alu_or    = bus.alu_a | bus.alu_b;
    assign bus.alu_xor   = bus.alu_a ^ bus.alu_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready low, then hand the result off.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] er, input logic ef,
                          input logic ei, input int elat, output logic [3:0] cseq);
        int lat;
        cseq = '0;
        check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = a ^ 4'h5;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (lat < 4) cseq[lat] = bus.alu_c;
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_result"}, {28'b0, bus.out_result}, {28'b0, er});
        check({tag, "_flag"}, {31'b0, bus.out_flag}, {31'b0, ef});
        check({tag, "_illegal"}, {31'b0, bus.out_illegal}, {31'b0, ei});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_back_idle"}, {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    initial begin
        logic [3:0] cs;
        int e1, e2, n;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        #2;
        check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_outs", {24'b0, bus.out_valid, bus.out_flag, bus.out_illegal,
              bus.out_result, 1'b0}, 32'd0);
        check("rst_alu", {29'b0, bus.alu_a, bus.alu_b, bus.alu_c}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("add_7_5", 3'b000, 4'd7, 4'd5, 4'd12, 1'b0, 1'b0, 4, cs);
        check("add_7_5_cseq", {28'b0, cs}, 32'b1110);
        run_op("add_9_9", 3'b000, 4'd9, 4'd9, 4'd2, 1'b1, 1'b0, 4, cs);
        run_op("sub_3_5", 3'b001, 4'd3, 4'd5, 4'd14, 1'b1, 1'b0, 4, cs);
        run_op("sub_12_4", 3'b001, 4'd12, 4'd4, 4'd8, 1'b0, 1'b0, 4, cs);
        run_op("and", 3'b010, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 4, cs);
        check("and_cseq", {28'b0, cs}, 32'd0);
        run_op("or", 3'b011, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 4, cs);
        check("or_cseq", {28'b0, cs}, 32'd0);
        run_op("xor", 3'b100, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 4, cs);
        check("xor_cseq", {28'b0, cs}, 32'd0);

        // reserved op, result held while out_ready low, new request ignored
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b110;
        bus.in_a     = 4'h3;
        bus.in_b     = 4'h3;
        tick();
        bus.in_op = 3'b000;
        check("rsv_valid", {31'b0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rsv_hold", {26'b0, bus.out_valid, bus.in_ready, bus.out_illegal,
                  bus.out_flag, 2'b0} | {28'b0, bus.out_result}, 32'b101000);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("rsv_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
        check("rsv_keep", {31'b0, bus.out_illegal}, 32'd1);

        // reset during the 2nd RUN cycle of ADD 15+1
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b000;
        bus.in_a     = 4'd15;
        bus.in_b     = 4'd1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_c", {31'b0, bus.alu_c}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
        check("arst_outs", {26'b0, bus.out_flag, bus.out_illegal, bus.out_result},
              32'd0);
        check("arst_alu", {29'b0, bus.alu_a, bus.alu_b, bus.alu_c}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_no_valid", {31'b0, bus.out_valid}, 32'd0);
        run_op("add_1_1", 3'b000, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 4, cs);

        // back-to-back with out_ready high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'b000;
        bus.in_a      = 4'd3;
        bus.in_b      = 4'd4;
        tick();
        e1 = cyc;
        bus.in_op = 3'b001;
        bus.in_a  = 4'd2;
        bus.in_b  = 4'd1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            if (bus.out_valid) check("b2b_r1", {28'b0, bus.out_result}, 32'd7);
            tick();
            n++;
        end
        tick();
        e2 = cyc;
        bus.in_valid = 1'b0;
        check("b2b_spacing", e2 - e1, W + 2);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("b2b_r2_lat", n, W);
        check("b2b_r2", {27'b0, bus.out_flag, bus.out_result}, 32'd1);
        tick();
        bus.out_ready = 1'b0;
        check("b2b_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
